// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit controller.
//   - RV32I funct3 size encodings for loads/stores
//   - FSM state enumeration
//   - helper that flags reserved funct3 codes
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } lsu_state_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational datapath helpers for lsu_ctrl.
//   chk_funct3/chk_addr -> bad       : illegal funct3 or misaligned access
//   funct3/addr_lo/rdata -> extracted: byte/half/word pulled from rdata, sign or zero extended
//   funct3/addr_lo/wdata/rdata -> merged: rdata with store byte/half inserted at addr_lo
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_addr,
    output logic        bad,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [15:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Only the low two funct3 bits encode size; bit 2 selects zero-extension.
    assign bad = f3_illegal(chk_funct3)
               || ((chk_funct3[1:0] == 2'b01) && chk_addr[0])
               || ((chk_funct3[1:0] == 2'b10) && (chk_addr != 2'b00));

    always_comb begin
        bsh       = {addr_lo, 3'b000};
        hsh       = {addr_lo[1], 4'b0000};
        byte_v    = 8'(rdata >> bsh);
        half_v    = 16'(rdata >> hsh);
        extracted = rdata;
        merged    = rdata;
        case (funct3[1:0])
            2'b00: begin
                extracted = {{24{byte_v[7] & ~funct3[2]}}, byte_v};
                merged    = (rdata & ~(32'h0000_00FF << bsh)) | ({24'b0, wdata[7:0]} << bsh);
            end
            2'b01: begin
                extracted = {{16{half_v[15] & ~funct3[2]}}, half_v};
                merged    = (rdata & ~(32'h0000_FFFF << hsh)) | ({16'b0, wdata} << hsh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between a core and a
// word-wide data memory with combinational read and clocked write.
//   core side  : req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata,
//                resp_valid/resp_rdata/resp_err
//   memory side: MemRead/MemWrite/Address/writeData, readData
// Sub-word stores are done as read-modify-write of the containing word.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    lsu_state_t  state, state_nx;
    logic [31:0] addr_q, wdata_q, merged_q;
    logic [2:0]  funct3_q;
    logic        err_q;
    logic        accept, bad;
    logic [31:0] merged, extracted;

    assign accept = req_valid && req_ready;

    lsu_align u_align (
        .chk_funct3 (req_funct3),
        .chk_addr   (req_addr[1:0]),
        .bad        (bad),
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q[15:0]),
        .rdata      (readData),
        .merged     (merged),
        .extracted  (extracted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            err_q      <= 1'b0;
            merged_q   <= '0;
            resp_rdata <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                err_q    <= bad;
            end
            if (state == LOAD)   resp_rdata <= extracted;
            if (state == RMW_RD) merged_q   <= merged;
        end
    end

    // All outputs decode from registered state, so an async reset clears
    // MemWrite before the next edge and the in-flight write never lands.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = {addr_q[31:2], 2'b00};
        writeData  = (funct3_q[1:0] == 2'b10) ? wdata_q : merged_q;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (bad)                          state_nx = DONE;
                    else if (!req_write)              state_nx = LOAD;
                    else if (req_funct3[1:0] == 2'b10) state_nx = WRITE;
                    else                              state_nx = RMW_RD;
                end
            end
            LOAD: begin
                MemRead  = 1'b1;
                state_nx = DONE;
            end
            RMW_RD: begin
                MemRead  = 1'b1;
                state_nx = WRITE;
            end
            WRITE: begin
                MemWrite = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed stimulus with a scoreboard; the driver pushes the
// expected response/write for each request, monitors pop and compare.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err, MemRead, MemWrite;
    logic [31:0] resp_rdata, Address, writeData, readData;

    lsu_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
        .writeData(writeData), .readData(readData)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge.
    logic [31:0] mem [0:15];
    logic        preload = 1'b1;
    assign readData = mem[Address[5:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h8899AABB;
            mem[12] <= 32'h11223344;
        end else if (MemWrite) begin
            mem[Address[5:2]] <= writeData;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; int due; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int due; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];
    resp_t re;
    wr_t   we;

    int checks = 0, errors = 0;
    int rd_seen = 0, exp_reads = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every completion and every memory write against the queues.
    always @(negedge clk) begin
        check("rw_exclusive", {31'b0, MemRead & MemWrite}, 32'h0);
        if (!resp_valid) check("err_without_valid", {31'b0, resp_err}, 32'h0);
        if (MemRead) rd_seen++;
        if (resp_valid) begin
            if (rq.size() == 0) check("resp_unexpected", 32'h1, 32'h0);
            else begin
                re = rq.pop_front();
                check("resp_rdata", resp_rdata, re.rdata);
                check("resp_err", {31'b0, resp_err}, {31'b0, re.err});
                check("resp_cycle", cyc, re.due);
            end
        end
        if (MemWrite) begin
            if (wq.size() == 0) check("write_unexpected", 32'h1, 32'h0);
            else begin
                we = wq.pop_front();
                check("wr_addr", Address, we.addr);
                check("wr_data", writeData, we.data);
                check("wr_cycle", cyc, we.due);
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, push expectations.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic [31:0] exp_wd, input logic exp_err,
                         input int lat, input logic hold, input logic expect_resp,
                         output int t);
        int n;
        resp_t r;
        wr_t   x;
        @(negedge clk);
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        t = cyc;
        if (n >= 50) begin
            check("accept_timeout", 32'h1, 32'h0);
            req_valid = 1'b0;
            return;
        end
        if (!exp_err && (!w || f3[1:0] != 2'b10)) exp_reads++;
        if (!exp_err && !w) last_rd = exp_rd;
        if (!exp_err && w) begin
            x.addr = {a[31:2], 2'b00}; x.data = exp_wd; x.due = t + lat - 1;
            wq.push_back(x);
        end
        if (expect_resp) begin
            r.rdata = last_rd; r.err = exp_err; r.due = t + lat;
            rq.push_back(r);
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    int t1, t2, t3, n;

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_memrw", {30'b0, MemRead, MemWrite}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_addr", Address, 32'h0);
        check("rst_wdata", writeData, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        reset = 1'b0;

        // loads over 0x8899AABB at 0x10
        issue(0, 3'b000, 32'h11, 0, 32'hFFFFFFAA, 0, 0, 2, 0, 1, t1);
        issue(0, 3'b100, 32'h11, 0, 32'h000000AA, 0, 0, 2, 0, 1, t1);
        issue(0, 3'b101, 32'h12, 0, 32'h00008899, 0, 0, 2, 0, 1, t1);
        issue(0, 3'b001, 32'h12, 0, 32'hFFFF8899, 0, 0, 2, 0, 1, t1);
        issue(0, 3'b010, 32'h10, 0, 32'h8899AABB, 0, 0, 2, 0, 1, t1);
        // sub-word stores via read-modify-write
        issue(1, 3'b000, 32'h12, 32'h000000CC, 0, 32'h88CCAABB, 0, 3, 0, 1, t1);
        issue(0, 3'b010, 32'h10, 0, 32'h88CCAABB, 0, 0, 2, 0, 1, t1);
        issue(1, 3'b001, 32'h10, 32'hFFFF1234, 0, 32'h88CC1234, 0, 3, 0, 1, t1);
        issue(0, 3'b000, 32'h10, 0, 32'h00000034, 0, 0, 2, 0, 1, t1);
        issue(0, 3'b000, 32'h12, 0, 32'hFFFFFFCC, 0, 0, 2, 0, 1, t1);
        issue(0, 3'b001, 32'h10, 0, 32'h00001234, 0, 0, 2, 0, 1, t1);
        // rejected requests
        issue(0, 3'b001, 32'h13, 0, 0, 0, 1, 1, 0, 1, t1);
        issue(1, 3'b010, 32'h22, 32'h1, 0, 0, 1, 1, 0, 1, t1);
        issue(0, 3'b011, 32'h10, 0, 0, 0, 1, 1, 0, 1, t1);
        issue(1, 3'b111, 32'h10, 32'h1, 0, 0, 1, 1, 0, 1, t1);
        issue(1, 3'b001, 32'h11, 32'h1, 0, 0, 1, 1, 0, 1, t1);
        // word store then load back
        issue(1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 2, 0, 1, t1);
        issue(0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0, 0, 2, 0, 1, t1);
        drain();

        // req_valid held across three back-to-back loads
        issue(0, 3'b010, 32'h10, 0, 32'h88CC1234, 0, 0, 2, 1, 1, t1);
        issue(0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0, 0, 2, 1, 1, t2);
        issue(0, 3'b010, 32'h30, 0, 32'h11223344, 0, 0, 2, 0, 1, t3);
        check("b2b_gap1", t2 - t1, 32'd3);
        check("b2b_gap2", t3 - t2, 32'd3);
        drain();

        // reset pulsed during the write phase of a byte store
        issue(1, 3'b000, 32'h31, 32'h00000055, 0, 32'h11225544, 0, 3, 0, 0, t1);
        n = 0;
        while (!MemWrite && n < 10) begin @(negedge clk); n++; end
        check("rmw_reached_write", {31'b0, MemWrite}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rst_drops_memwrite", {31'b0, MemWrite}, 32'h0);
        check("rst_ready_mid", {31'b0, req_ready}, 32'h1);
        check("rst_rdata_mid", resp_rdata, 32'h0);
        last_rd = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'h1);
        check("mem_unchanged", mem[12], 32'h11223344);
        issue(0, 3'b010, 32'h30, 0, 32'h11223344, 0, 0, 2, 0, 1, t1);
        drain();

        check("resp_queue_empty", rq.size(), 32'h0);
        check("write_queue_empty", wq.size(), 32'h0);
        check("memread_cycles", rd_seen, exp_reads);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
